// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - multiplexed hex 7-segment scan driver with frame-latched loads and PWM dimming
//
// Purpose:
//   Time-multiplexes DIGITS hex digits onto one shared 8-bit segment bus.
//   A new value/dots pair is requested with a one-cycle load pulse. It is
//   held in a pending register and only copied to the display register at
//   a frame boundary, so a frame never mixes old and new digits.
//   Each digit slot lasts SCAN_DIV clocks. Inside a slot the digit enable
//   is pulse-width modulated by a brightness code.
//
// Parameters:
//   DIGITS       number of multiplexed digits (>= 2)
//   SCAN_DIV     clocks per digit slot, power of two, >= 2*2^DIM_BITS
//   DIM_BITS     brightness resolution in bits
//   COMMON_ANODE 1: seg_out active-low, 0: seg_out active-high
//
// Ports:
//   CLK          system clock
//   RST_N        asynchronous active-low reset
//   value_in     hex nibbles, nibble 0 (bits 3:0) is the rightmost digit
//   dots_in      decimal point per digit, 1 = lit
//   blank_lz     1 = suppress leading zeros
//   brightness   on-time code, all-ones = maximum
//   load         one-cycle request to adopt value_in/dots_in
//   load_ack     one-cycle pulse when a load reaches the display
//   frame_tick   one-cycle pulse at every frame boundary
//   seg_out      bit 7 = dp, bits 6:0 = g..a
//   dig_en       active-high digit select, one-hot or all-zero
module seg7_scan_driver #(
  parameter int DIGITS       = 4,
  parameter int SCAN_DIV     = 4096,
  parameter int DIM_BITS     = 4,
  parameter bit COMMON_ANODE = 1'b1
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [4*DIGITS-1:0]   value_in,
  input  logic [DIGITS-1:0]     dots_in,
  input  logic                  blank_lz,
  input  logic [DIM_BITS-1:0]   brightness,
  input  logic                  load,
  output logic                  load_ack,
  output logic                  frame_tick,
  output logic [7:0]            seg_out,
  output logic [DIGITS-1:0]     dig_en
);

  localparam int SLOT_W = $clog2(SCAN_DIV);
  localparam int IDX_W  = $clog2(DIGITS);

  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);

  // Segment bus level with every segment and the dp dark.
  localparam logic [7:0] SEG_OFF = COMMON_ANODE ? 8'hFF : 8'h00;

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic [SLOT_W-1:0]   slot_cnt;
  logic [IDX_W-1:0]    idx;
  logic [DIM_BITS-1:0] bri_q;

  logic                pend;
  logic [4*DIGITS-1:0] pend_val;
  logic [DIGITS-1:0]   pend_dots;

  logic [4*DIGITS-1:0] disp_val;
  logic [DIGITS-1:0]   disp_dots;

  // ---------------------------------------------------------------------
  // Hex font, active-low g..a (bit 6 = g, bit 0 = a)
  // ---------------------------------------------------------------------
  function automatic logic [6:0] hex_font(input logic [3:0] nib);
    logic [6:0] f;
    case (nib)
      4'h0:    f = 7'b1000000;
      4'h1:    f = 7'b1111001;
      4'h2:    f = 7'b0100100;
      4'h3:    f = 7'b0110000;
      4'h4:    f = 7'b0011001;
      4'h5:    f = 7'b0010010;
      4'h6:    f = 7'b0000010;
      4'h7:    f = 7'b1111000;
      4'h8:    f = 7'b0000000;
      4'h9:    f = 7'b0010000;
      4'hA:    f = 7'b0001000;
      4'hB:    f = 7'b0000011;
      4'hC:    f = 7'b1000110;
      4'hD:    f = 7'b0100001;
      4'hE:    f = 7'b0000110;
      default: f = 7'b0001110;
    endcase
    return f;
  endfunction

  // ---------------------------------------------------------------------
  // Scan timing
  // ---------------------------------------------------------------------
  logic slot_wrap;
  logic frame_end;

  assign slot_wrap = (slot_cnt == SLOT_LAST);
  // Last cycle of the last slot: the display register is swapped on this
  // edge so the first slot of the next frame already shows the new value.
  assign frame_end = slot_wrap && (idx == IDX_LAST);

  // ---------------------------------------------------------------------
  // Leading-zero mask: lz_mask[i] is set when nibbles i..DIGITS-1 of the
  // display register are all zero. Digit 0 is never part of the mask.
  // ---------------------------------------------------------------------
  logic [DIGITS-1:0] lz_mask;
  logic              lz_run;

  always_comb begin
    lz_mask = '0;
    lz_run  = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      lz_run     = lz_run && (disp_val[4*i +: 4] == 4'h0);
      lz_mask[i] = lz_run;
    end
  end

  // ---------------------------------------------------------------------
  // Current digit selection
  // ---------------------------------------------------------------------
  logic [3:0]        cur_nib;
  logic              cur_dot;
  logic              cur_lz;
  logic [DIGITS-1:0] dig_sel;

  always_comb begin
    cur_nib = 4'h0;
    cur_dot = 1'b0;
    cur_lz  = 1'b0;
    dig_sel = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_nib    = disp_val[4*i +: 4];
        cur_dot    = disp_dots[i];
        cur_lz     = lz_mask[i];
        dig_sel[i] = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Segment and enable next-state
  // ---------------------------------------------------------------------
  logic       cur_blank;
  logic       cur_lit;
  logic [7:0] seg_low;
  logic [7:0] seg_next;

  assign cur_blank = blank_lz && cur_lz;

  // Cycle 0 of every slot is a dark guard cycle so the segment bus can
  // settle on the new digit before its enable rises (no ghosting).
  assign cur_lit = (slot_cnt != '0) &&
                   (slot_cnt[SLOT_W-1 -: DIM_BITS] <= bri_q);

  // Built active-low (lit = 0), then flipped for common-cathode parts.
  assign seg_low  = {~cur_dot, cur_blank ? 7'h7F : hex_font(cur_nib)};
  assign seg_next = COMMON_ANODE ? seg_low : ~seg_low;

  // ---------------------------------------------------------------------
  // Sequential logic
  // ---------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      slot_cnt   <= '0;
      idx        <= '0;
      bri_q      <= '0;
      pend       <= 1'b0;
      pend_val   <= '0;
      pend_dots  <= '0;
      disp_val   <= '0;
      disp_dots  <= '0;
      load_ack   <= 1'b0;
      frame_tick <= 1'b0;
      dig_en     <= '0;
      seg_out    <= SEG_OFF;
    end else begin
      // Slot and digit counters
      if (slot_wrap) begin
        slot_cnt <= '0;
        idx      <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
      end else begin
        slot_cnt <= slot_cnt + SLOT_W'(1);
      end

      // Brightness is frozen for the whole slot so a change cannot cut a
      // pulse short or stretch it mid-slot.
      if (slot_cnt == '0) begin
        bri_q <= brightness;
      end

      // Latest load always wins in the pending register.
      if (load) begin
        pend_val  <= value_in;
        pend_dots <= dots_in;
      end

      if (frame_end) begin
        pend <= 1'b0;
        // A load on the boundary cycle itself bypasses the pending copy.
        if (load) begin
          disp_val  <= value_in;
          disp_dots <= dots_in;
        end else if (pend) begin
          disp_val  <= pend_val;
          disp_dots <= pend_dots;
        end
      end else if (load) begin
        pend <= 1'b1;
      end

      load_ack   <= frame_end && (pend || load);
      frame_tick <= frame_end;
      dig_en     <= cur_lit ? dig_sel : '0;
      seg_out    <= seg_next;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - scoreboard bench for seg7_scan_driver
module tb_seg7_scan_driver;

  localparam int DIGITS   = 4;
  localparam int SCAN_DIV = 16;
  localparam int DIM_BITS = 2;
  localparam int FRAME    = DIGITS * SCAN_DIV;

  logic        clk;
  logic        rst_n;
  logic [15:0] value_in;
  logic [3:0]  dots_in;
  logic        blank_lz;
  logic [1:0]  brightness;
  logic        load;
  logic        load_ack;
  logic        frame_tick;
  logic [7:0]  seg_out;
  logic [3:0]  dig_en;

  seg7_scan_driver #(
    .DIGITS      (DIGITS),
    .SCAN_DIV    (SCAN_DIV),
    .DIM_BITS    (DIM_BITS),
    .COMMON_ANODE(1'b1)
  ) dut (
    .CLK       (clk),
    .RST_N     (rst_n),
    .value_in  (value_in),
    .dots_in   (dots_in),
    .blank_lz  (blank_lz),
    .brightness(brightness),
    .load      (load),
    .load_ack  (load_ack),
    .frame_tick(frame_tick),
    .seg_out   (seg_out),
    .dig_en    (dig_en)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Active-low g..a font, digits 0..F
  logic [6:0] font [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // ---------------------------------------------------------------------
  // Reference model: expected {frame_tick, load_ack, dig_en, seg_out} for
  // the output produced by each clock edge, queued for the checker.
  // ---------------------------------------------------------------------
  logic [13:0] sb_q [$];
  int          m_t    = 0;
  int          m_bri  = 0;
  logic        m_pend = 1'b0;
  logic [15:0] m_disp = '0;
  logic [15:0] m_pv   = '0;
  logic [3:0]  m_dots = '0;
  logic [3:0]  m_pd   = '0;
  int          m_slot, m_dg;
  logic        m_bnd, m_lit, m_blank;
  logic [3:0]  m_nib, m_de;
  logic [7:0]  m_seg;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_t = 0; m_bri = 0; m_pend = 1'b0;
      m_disp = '0; m_pv = '0; m_dots = '0; m_pd = '0;
      sb_q.delete();
    end else begin
      m_slot = m_t % SCAN_DIV;
      m_dg   = (m_t / SCAN_DIV) % DIGITS;
      m_bnd  = (m_t % FRAME) == FRAME - 1;
      if (m_slot == 0) m_bri = int'(brightness);
      m_lit   = (m_slot != 0) && ((m_slot / (SCAN_DIV / 4)) <= m_bri);
      m_nib   = m_disp[4*m_dg +: 4];
      m_blank = blank_lz && (m_dg >= 1) && ((m_disp >> (4 * m_dg)) == 16'h0);
      m_seg   = {~m_dots[m_dg], m_blank ? 7'h7F : font[m_nib]};
      m_de    = m_lit ? (4'b0001 << m_dg) : 4'b0000;
      sb_q.push_back({m_bnd, m_bnd && (m_pend || load), m_de, m_seg});
      if (m_bnd) begin
        if (load) begin
          m_disp = value_in; m_dots = dots_in;
        end else if (m_pend) begin
          m_disp = m_pv; m_dots = m_pd;
        end
        m_pend = 1'b0;
      end else if (load) begin
        m_pend = 1'b1;
      end
      if (load) begin
        m_pv = value_in; m_pd = dots_in;
      end
      m_t++;
    end
  end

  // ---------------------------------------------------------------------
  // Checker and event monitors, sampled on the falling edge
  // ---------------------------------------------------------------------
  int          ack_cnt   = 0;
  int          seen1_cnt = 0;
  logic [13:0] sb_exp;

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      check_eq("reset_out", {frame_tick, load_ack, dig_en, seg_out}, 14'h00FF);
    end else if (sb_q.size() > 0) begin
      sb_exp = sb_q.pop_front();
      check_eq("scan_out", {frame_tick, load_ack, dig_en, seg_out}, sb_exp);
    end
    if (rst_n && load_ack) ack_cnt++;
    if (rst_n && dig_en != 4'b0 && seg_out[6:0] == 7'h79) seen1_cnt++;
  end

  // ---------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------
  int         lit_c   [4];
  int         first_c [4];
  logic [7:0] seg_c   [4];

  task automatic load_pulse(input logic [15:0] v, input logic [3:0] d);
    @(posedge clk); #1;
    value_in = v; dots_in = d; load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
  endtask

  task automatic wait_tick(input string tag, input int budget);
    int n = 0;
    while (1) begin
      @(negedge clk);
      n++;
      if (frame_tick) break;
      if (n >= budget) begin
        check_eq(tag, frame_tick, 1);
        break;
      end
    end
  endtask

  task automatic wait_ack(input string tag, input int budget);
    int n = 0;
    while (1) begin
      @(negedge clk);
      n++;
      if (load_ack) break;
      if (n >= budget) begin
        check_eq(tag, load_ack, 1);
        break;
      end
    end
  endtask

  // Edges from reset release to the first frame_tick output.
  task automatic first_tick_delay(output int n);
    n = 0;
    do begin
      @(posedge clk); n++; #1;
    end while (!frame_tick && n < 4 * FRAME);
  endtask

  // Call on the falling edge that showed frame_tick; observes the next frame.
  task automatic collect_frame();
    int d;
    for (int k = 0; k < 4; k++) begin
      lit_c[k] = 0; first_c[k] = -1; seg_c[k] = 8'h00;
    end
    for (int j = 0; j < FRAME; j++) begin
      @(negedge clk);
      d = j / SCAN_DIV;
      if (dig_en == (4'b0001 << d)) begin
        lit_c[d]++;
        seg_c[d] = seg_out;
        if (first_c[d] < 0) first_c[d] = j % SCAN_DIV;
      end
    end
  endtask

  // ---------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------
  logic [7:0] exp_t2 [4];
  int         n, a0, s0;

  initial begin
    rst_n = 1'b1; load = 1'b0; value_in = '0; dots_in = '0;
    blank_lz = 1'b0; brightness = 2'd3;
    exp_t2 = '{8'h8E, 8'h88, 8'h24, 8'hF9};
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset release to first frame boundary
    first_tick_delay(n);
    check_eq("t1_first_tick", n, FRAME);

    // Scan and decode
    load_pulse(16'h12AF, 4'b0100);
    wait_ack("t2_ack", 2 * FRAME);
    collect_frame();
    for (int k = 0; k < 4; k++) begin
      check_eq($sformatf("t2_lit%0d", k), lit_c[k], 15);
      check_eq($sformatf("t2_seg%0d", k), seg_c[k], exp_t2[k]);
    end

    // Leading-zero blanking
    blank_lz = 1'b1;
    load_pulse(16'h0005, 4'b0000);
    wait_ack("t3a_ack", 2 * FRAME);
    collect_frame();
    check_eq("t3a_seg0", seg_c[0], 8'h92);
    for (int k = 1; k < 4; k++) check_eq($sformatf("t3a_seg%0d", k), seg_c[k], 8'hFF);
    load_pulse(16'h0000, 4'b0000);
    wait_ack("t3b_ack", 2 * FRAME);
    collect_frame();
    check_eq("t3b_seg0", seg_c[0], 8'hC0);
    check_eq("t3b_seg3", seg_c[3], 8'hFF);

    // Load handshake: two loads in one frame, latest wins
    blank_lz = 1'b0;
    wait_tick("t4_sync", 2 * FRAME);
    a0 = ack_cnt; s0 = seen1_cnt;
    repeat (20) @(posedge clk);
    #1 value_in = 16'h1111; dots_in = 4'b0000; load = 1'b1;
    @(posedge clk);
    #1 load = 1'b0;
    repeat (15) @(posedge clk);
    #1 value_in = 16'h2222; load = 1'b1;
    @(posedge clk);
    #1 load = 1'b0;
    wait_ack("t4_ack", 2 * FRAME);
    check_eq("t4_ack_with_tick", frame_tick, 1);
    collect_frame();
    check_eq("t4_ack_count", ack_cnt - a0, 1);
    for (int k = 0; k < 4; k++) check_eq($sformatf("t4_seg%0d", k), seg_c[k], 8'hA4);
    check_eq("t4_no_1111", seen1_cnt - s0, 0);

    // Brightness, including a change in the middle of a slot
    brightness = 2'd1;
    wait_tick("t5_sync", 2 * FRAME);
    collect_frame();
    for (int k = 0; k < 4; k++) check_eq($sformatf("t5a_lit%0d", k), lit_c[k], 7);
    check_eq("t5a_first", first_c[0], 1);
    fork
      collect_frame();
      begin
        repeat (4) @(posedge clk);
        #1 brightness = 2'd0;
      end
    join
    check_eq("t5b_lit0", lit_c[0], 7);
    check_eq("t5b_lit1", lit_c[1], 3);
    check_eq("t5b_first1", first_c[1], 1);
    check_eq("t5b_lit3", lit_c[3], 3);

    // Reset in the middle of a frame drops the pending load
    brightness = 2'd3;
    wait_tick("t6_sync", 2 * FRAME);
    a0 = ack_cnt;
    load_pulse(16'h5678, 4'b1111);
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    first_tick_delay(n);
    check_eq("t6_first_tick", n, FRAME);
    wait_tick("t6_sync2", 2 * FRAME);
    collect_frame();
    check_eq("t6_no_ack", ack_cnt - a0, 0);
    for (int k = 0; k < 4; k++) check_eq($sformatf("t6_seg%0d", k), seg_c[k], 8'hC0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Parametrised multiplexed 7-segment display driver for the 4-digit LED module and larger variants. It time-multiplexes DIGITS hex digits onto one shared 8-bit segment bus. Features:
- per-digit decimal points
- leading-zero blanking
- PWM brightness
- tear-free value updates, latched at frame boundaries through a load/ack handshake

It sits between the application counters and the segment/digit pins in `top`.

## Interface
- DIGITS, 4: number of multiplexed digits (≥2).
- SCAN_DIV, 4096: clock cycles per digit slot. Power of two, ≥ 2^DIM_BITS·2.
- DIM_BITS, 4: brightness resolution in bits.
- COMMON_ANODE, 1: 1 = seg_out active-low; 0 = seg_out active-high. dig_en is active-high in both modes.
- CLK  in  1  system clock.
- RST_N  in  1  asynchronous, active-low reset.
- value_in  in  4·DIGITS  hex nibbles; nibble 0 (bits 3:0) = rightmost digit.
- dots_in  in  DIGITS  decimal point request per digit, 1 = lit.
- blank_lz  in  1  1 = suppress leading zeros.
- brightness  in  DIM_BITS  on-time code; all-ones = maximum.
- load  in  1  one-cycle request to adopt value_in/dots_in.
- load_ack  out  1  one-cycle pulse when a load takes effect on the display.
- frame_tick  out  1  one-cycle pulse at every frame boundary.
- seg_out  out  8  bit 7 = dp, bits 6:0 = g..a.
- dig_en  out  DIGITS  digit select, one-hot or all-zero.

## Operation
**Scan counters**
- slot_cnt counts 0..SCAN_DIV-1.
- idx advances when slot_cnt wraps and itself wraps DIGITS-1→0.
- The idx wrap is the frame boundary.

**Load path**
- load captures value_in/dots_in into a pending register and sets pend.
- A further load before the boundary overwrites pending; the latest load wins.

**Frame boundary**
- If pend is set or load is asserted this cycle, the display register takes the load-cycle value when load=1, otherwise the pending value.
- pend clears and load_ack pulses in the same cycle as frame_tick.
- Otherwise the display register holds.

**Decode**
- Standard hex font 0–F: 0=1000000, 1=1111001, …, 8=0000000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110 (active-low g..a).
- The dp bit comes from the display register's dots bit for idx.

**Leading-zero blanking**
- Digit i (i≥1) is blanked when blank_lz=1 and nibbles i..DIGITS-1 are all zero.
- Digit 0 is never blanked.
- A blanked digit drives segments 6:0 off; dp still follows dots.

**Brightness**
- brightness is sampled at slot_cnt==0 into bri_q, so changes never glitch mid-slot.
- The digit is lit while slot_cnt[log2(SCAN_DIV)-1 -: DIM_BITS] ≤ bri_q and slot_cnt≠0.

**Ghost guard and polarity**
- dig_en is all-zero on slot_cnt==0 (ghost guard); segments switch to the new digit in that cycle.
- COMMON_ANODE=0 inverts all 8 seg_out bits; dig_en is unaffected.

## Timing
- Every output is registered and reflects the internal state of the preceding cycle (1-cycle latency).
- Frame length is DIGITS·SCAN_DIV cycles. frame_tick period equals the frame length exactly.
- load→load_ack latency ranges from 1 cycle (load on the boundary cycle) to DIGITS·SCAN_DIV cycles.
- During its slot, the active digit has (bri_q+1)·SCAN_DIV/2^DIM_BITS − 1 lit cycles.
- Reset (asynchronous assert, synchronous-to-CLK deassert handled upstream) sets:
  - slot_cnt=0, idx=0, pend=0
  - display/pending registers = 0
  - dig_en=0, seg_out = all segments off (8'hFF when COMMON_ANODE=1, 8'h00 when 0)
  - load_ack=0, frame_tick=0
- Reset mid-frame discards any pending load; no load_ack is issued for it.
- load held high for several cycles counts as repeated loads; the last value wins, with a single load_ack per boundary.

## Test plan
All scenarios use DIGITS=4, SCAN_DIV=16, DIM_BITS=2, COMMON_ANODE=1.

1. **Reset state:** RST_N low → dig_en=4'b0000, seg_out=8'hFF, load_ack=0; release → first frame_tick 64 cycles later.
2. **Scan and decode:** load value_in=16'h12AF, dots_in=4'b0100, brightness=3 → after load_ack:
   - slots show F (0001110), A, 2, 1 in order dig_en=0001,0010,0100,1000
   - dp (bit 7) low only in the 0100 slot
   - 15 lit cycles per slot
3. **Leading-zero blanking:** value_in=16'h0005, blank_lz=1 → seg_out[6:0]=1111111 in digits 3..1, digit 0 shows 0010010; value_in=16'h0000 → digit 0 shows 1000000.
4. **Load handshake:** load 16'h1111 at slot 1, then 16'h2222 at slot 2 of the same frame → exactly one load_ack, coincident with frame_tick; display shows 2222; 1111 never appears.
5. **Brightness:** brightness=1 → dig_en high for 7 cycles per 16-cycle slot (cycles 1–7); change brightness to 0 at slot_cnt=4 → current slot unchanged, next slot lit for 3 cycles.
6. **Reset mid-frame:** load asserted, RST_N pulsed low before the boundary → no load_ack, display value 0 after reset.
